// File: rtl/gnrl_bitstr_capture_pkg.sv
// Shared definitions for the bitstream capture engine: one-hot FSM encoding and default widths.
package gnrl_bitstr_capture_pkg;

   localparam int BUS_WIDTH_DFLT = 32;
   localparam int CNT_WIDTH_DFLT = 16;

   localparam int ST_IDLE_BIT = 0;
   localparam int ST_CAPT_BIT = 1;
   localparam int ST_DONE_BIT = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'(1 << ST_IDLE_BIT),
      ST_CAPT = 3'(1 << ST_CAPT_BIT),
      ST_DONE = 3'(1 << ST_DONE_BIT)
   } cap_state_t;

endpackage

// File: rtl/gnrl_bitstr_capture.sv
// Bitstream capture: samples bitstr_in every DECIM+1 cycles after START, 2-edge pin-to-FIFO latency.
// A full FIFO drops the sample (sticky OVF) but the slot still counts, so capture time never stretches.
module gnrl_bitstr_capture
   import gnrl_bitstr_capture_pkg::*;
#(
   parameter int BUS_WIDTH = BUS_WIDTH_DFLT,
   parameter int CNT_WIDTH = CNT_WIDTH_DFLT
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 START,
   input  logic                 STOP,
   input  logic [CNT_WIDTH-1:0] NSAMP,
   input  logic [CNT_WIDTH-1:0] DECIM,
   input  logic [BUS_WIDTH-1:0] bitstr_in,
   input  logic                 fifo_full,
   output logic [BUS_WIDTH-1:0] fifo_wr_data,
   output logic                 fifo_wr_en,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 OVF,
   output logic [CNT_WIDTH-1:0] wr_cnt
);

   cap_state_t           state;
   logic [BUS_WIDTH-1:0] in_reg;
   logic [CNT_WIDTH-1:0] nsamp_q;
   logic [CNT_WIDTH-1:0] decim_q;
   logic [CNT_WIDTH-1:0] scnt;
   logic [CNT_WIDTH-1:0] dcnt;
   logic                 strobe;
   logic                 last_slot;

   assign strobe    = (dcnt == '0);
   assign last_slot = (scnt == nsamp_q - CNT_WIDTH'(1));

   // One-hot state bits are the status outputs directly.
   assign BUSY = state[ST_CAPT_BIT];
   assign DONE = state[ST_DONE_BIT];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= ST_IDLE;
         in_reg       <= '0;
         nsamp_q      <= '0;
         decim_q      <= '0;
         scnt         <= '0;
         dcnt         <= '0;
         fifo_wr_data <= '0;
         fifo_wr_en   <= 1'b0;
         OVF          <= 1'b0;
         wr_cnt       <= '0;
      end else begin
         in_reg     <= bitstr_in;
         fifo_wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  nsamp_q <= NSAMP;
                  decim_q <= DECIM;
                  scnt    <= '0;
                  dcnt    <= '0;
                  wr_cnt  <= '0;
                  OVF     <= 1'b0;
                  state   <= (NSAMP == '0) ? ST_DONE : ST_CAPT;
               end
            end
            ST_CAPT: begin
               // STOP pre-empts a coincident strobe: no write is issued that cycle.
               if (STOP) begin
                  state <= ST_DONE;
               end else if (strobe) begin
                  dcnt <= decim_q;
                  if (fifo_full) begin
                     OVF <= 1'b1;
                  end else begin
                     fifo_wr_data <= in_reg;
                     fifo_wr_en   <= 1'b1;
                     wr_cnt       <= wr_cnt + CNT_WIDTH'(1);
                  end
                  if (last_slot) begin
                     state <= ST_DONE;
                  end else begin
                     scnt <= scnt + CNT_WIDTH'(1);
                  end
               end else begin
                  dcnt <= dcnt - CNT_WIDTH'(1);
               end
            end
            ST_DONE: begin
               if (!START) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gnrl_bitstr_capture.sv
// Directed bench for gnrl_bitstr_capture; bitstr_in carries a ramp of BASE + cycle number.
module tb_gnrl_bitstr_capture;

   localparam int          BW   = 32;
   localparam int          CW   = 16;
   localparam logic [31:0] BASE = 32'h5A00_0000;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          START;
   logic          STOP;
   logic [CW-1:0] NSAMP;
   logic [CW-1:0] DECIM;
   logic [BW-1:0] bitstr_in;
   logic          fifo_full;
   logic [BW-1:0] fifo_wr_data;
   logic          fifo_wr_en;
   logic          BUSY;
   logic          DONE;
   logic          OVF;
   logic [CW-1:0] wr_cnt;

   int vec  = 0;
   int miss = 0;
   int cyc  = 0;

   logic [BW-1:0] wq_dat[$];
   int            wq_cyc[$];

   gnrl_bitstr_capture #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .START        (START),
      .STOP         (STOP),
      .NSAMP        (NSAMP),
      .DECIM        (DECIM),
      .bitstr_in    (bitstr_in),
      .fifo_full    (fifo_full),
      .fifo_wr_data (fifo_wr_data),
      .fifo_wr_en   (fifo_wr_en),
      .BUSY         (BUSY),
      .DONE         (DONE),
      .OVF          (OVF),
      .wr_cnt       (wr_cnt)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Ramp driven at each negedge: value BASE+c is sampled by posedge c+1, lands in in_reg,
   // and is written by a strobe at posedge c+2. So a write seen at cycle w carries BASE+w-2.
   initial begin
      bitstr_in = '0;
      forever begin
         @(negedge CLK);
         bitstr_in = BASE + 32'(cyc);
      end
   end

   always @(negedge CLK) begin
      if (fifo_wr_en === 1'b1) begin
         wq_dat.push_back(fifo_wr_data);
         wq_cyc.push_back(cyc);
      end
   end

   task automatic wait_done(input int budget, output int at_cyc, output bit timed_out);
      timed_out = 1'b1;
      at_cyc    = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (DONE === 1'b1) begin
            timed_out = 1'b0;
            at_cyc    = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset;
      RST_N = 1'b0; START = 1'b0; STOP = 1'b0; NSAMP = '0; DECIM = '0; fifo_full = 1'b0;
      repeat (3) @(negedge CLK);
      vec++;
      if ({fifo_wr_en, BUSY, DONE, OVF} !== 4'b0 || wr_cnt !== '0 || fifo_wr_data !== '0) begin
         miss++;
         $display("FAIL reset_hold: en/busy/done/ovf=%b wr_cnt=%0d data=%h, want all 0",
                  {fifo_wr_en, BUSY, DONE, OVF}, wr_cnt, fifo_wr_data);
      end
      #2 RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      vec++;
      if ({fifo_wr_en, BUSY, DONE, OVF} !== 4'b0 || wr_cnt !== '0) begin
         miss++;
         $display("FAIL reset_idle: en/busy/done/ovf=%b wr_cnt=%0d, want 0", {fifo_wr_en, BUSY, DONE, OVF}, wr_cnt);
      end
   endtask

   task automatic test_basic;
      int e0, dc, ec;
      bit to;
      wq_dat.delete(); wq_cyc.delete();
      NSAMP = 16'd4; DECIM = 16'd0; START = 1'b1; e0 = cyc + 1;
      @(negedge CLK);
      vec++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
         miss++; $display("FAIL basic_busy: busy=%b done=%b, want 1 0", BUSY, DONE);
      end
      wait_done(50, dc, to);
      vec++;
      if (to || dc != e0 + 4) begin
         miss++; $display("FAIL basic_done_cycle: got %0d (timeout=%0d), want %0d", dc, to, e0 + 4);
      end
      vec++;
      if (wr_cnt !== 16'd4 || OVF !== 1'b0 || BUSY !== 1'b0) begin
         miss++; $display("FAIL basic_status: wr_cnt=%0d ovf=%b busy=%b, want 4 0 0", wr_cnt, OVF, BUSY);
      end
      START = 1'b0;
      @(negedge CLK);
      vec++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
         miss++; $display("FAIL basic_to_idle: done=%b busy=%b, want 0 0", DONE, BUSY);
      end
      repeat (3) @(negedge CLK);
      vec++;
      if (wq_cyc.size() != 4) begin
         miss++; $display("FAIL basic_nwrites: got %0d, want 4", wq_cyc.size());
      end
      for (int k = 0; k < 4 && k < wq_cyc.size(); k++) begin
         ec = e0 + 1 + k;
         vec++;
         if (wq_cyc[k] != ec || wq_dat[k] !== BASE + 32'(ec - 2)) begin
            miss++;
            $display("FAIL basic_write%0d: cyc=%0d data=%h, want cyc=%0d data=%h",
                     k, wq_cyc[k], wq_dat[k], ec, BASE + 32'(ec - 2));
         end
      end
   endtask

   task automatic test_decim;
      int e0, dc, ec;
      bit to;
      wq_dat.delete(); wq_cyc.delete();
      NSAMP = 16'd3; DECIM = 16'd2; START = 1'b1; e0 = cyc + 1;
      @(negedge CLK);
      // Changing the programming mid-capture must not matter.
      NSAMP = 16'd1; DECIM = 16'd0;
      wait_done(50, dc, to);
      vec++;
      if (to || dc != e0 + 7) begin
         miss++; $display("FAIL decim_done_cycle: got %0d (timeout=%0d), want %0d", dc, to, e0 + 7);
      end
      START = 1'b0;
      repeat (3) @(negedge CLK);
      vec++;
      if (wq_cyc.size() != 3 || wr_cnt !== 16'd3) begin
         miss++; $display("FAIL decim_nwrites: got %0d wr_cnt=%0d, want 3 3", wq_cyc.size(), wr_cnt);
      end
      for (int k = 0; k < 3 && k < wq_cyc.size(); k++) begin
         ec = e0 + 1 + 3 * k;
         vec++;
         if (wq_cyc[k] != ec || wq_dat[k] !== BASE + 32'(ec - 2)) begin
            miss++;
            $display("FAIL decim_write%0d: cyc=%0d data=%h, want cyc=%0d data=%h",
                     k, wq_cyc[k], wq_dat[k], ec, BASE + 32'(ec - 2));
         end
      end
   endtask

   task automatic test_overflow;
      int e0, dc, ec;
      bit to;
      int exp_off[6] = '{1, 2, 5, 6, 7, 8};
      wq_dat.delete(); wq_cyc.delete();
      NSAMP = 16'd8; DECIM = 16'd0; START = 1'b1; e0 = cyc + 1;
      repeat (3) @(negedge CLK);
      fifo_full = 1'b1;                 // seen by strobes 3 and 4
      repeat (2) @(negedge CLK);
      fifo_full = 1'b0;
      vec++;
      if (OVF !== 1'b1) begin
         miss++; $display("FAIL ovf_sticky: got %b, want 1", OVF);
      end
      wait_done(50, dc, to);
      vec++;
      if (to || dc != e0 + 8) begin
         miss++; $display("FAIL ovf_done_cycle: got %0d (timeout=%0d), want %0d", dc, to, e0 + 8);
      end
      vec++;
      if (wr_cnt !== 16'd6 || OVF !== 1'b1) begin
         miss++; $display("FAIL ovf_status: wr_cnt=%0d ovf=%b, want 6 1", wr_cnt, OVF);
      end
      START = 1'b0;
      repeat (3) @(negedge CLK);
      vec++;
      if (wq_cyc.size() != 6) begin
         miss++; $display("FAIL ovf_nwrites: got %0d, want 6", wq_cyc.size());
      end
      for (int k = 0; k < 6 && k < wq_cyc.size(); k++) begin
         ec = e0 + exp_off[k];
         vec++;
         if (wq_cyc[k] != ec || wq_dat[k] !== BASE + 32'(ec - 2)) begin
            miss++;
            $display("FAIL ovf_write%0d: cyc=%0d data=%h, want cyc=%0d data=%h",
                     k, wq_cyc[k], wq_dat[k], ec, BASE + 32'(ec - 2));
         end
      end
   endtask

   task automatic test_stop;
      int e0;
      wq_dat.delete(); wq_cyc.delete();
      NSAMP = 16'd100; DECIM = 16'd1; START = 1'b1; e0 = cyc + 1;
      repeat (21) @(negedge CLK);
      STOP = 1'b1;                      // sampled at e0+21, the 11th strobe
      @(negedge CLK);
      vec++;
      if (DONE !== 1'b1 || BUSY !== 1'b0 || fifo_wr_en !== 1'b0) begin
         miss++; $display("FAIL stop_done: done=%b busy=%b en=%b, want 1 0 0", DONE, BUSY, fifo_wr_en);
      end
      vec++;
      if (wr_cnt !== 16'd10 || wq_cyc.size() != 10) begin
         miss++; $display("FAIL stop_count: wr_cnt=%0d seen=%0d, want 10 10", wr_cnt, wq_cyc.size());
      end
      vec++;
      if (wq_cyc.size() == 0 || wq_cyc[wq_cyc.size() - 1] != e0 + 19) begin
         miss++; $display("FAIL stop_last_write: got cycle %0d, want %0d",
                          (wq_cyc.size() == 0) ? -1 : wq_cyc[wq_cyc.size() - 1], e0 + 19);
      end
      STOP = 1'b0;
      repeat (5) @(negedge CLK);
      vec++;
      if (DONE !== 1'b1 || BUSY !== 1'b0 || wq_cyc.size() != 10) begin
         miss++; $display("FAIL stop_hold: done=%b busy=%b writes=%0d, want 1 0 10", DONE, BUSY, wq_cyc.size());
      end
      START = 1'b0;
      @(negedge CLK);
      vec++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
         miss++; $display("FAIL stop_to_idle: done=%b busy=%b, want 0 0", DONE, BUSY);
      end
      STOP = 1'b1;
      repeat (2) @(negedge CLK);
      vec++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || wr_cnt !== 16'd10) begin
         miss++; $display("FAIL stop_idle_ignored: done=%b busy=%b wr_cnt=%0d, want 0 0 10", DONE, BUSY, wr_cnt);
      end
      STOP = 1'b0;
   endtask

   task automatic test_zero_and_reset;
      int e0;
      wq_dat.delete(); wq_cyc.delete();
      NSAMP = 16'd0; DECIM = 16'd0; START = 1'b1;
      @(negedge CLK);
      vec++;
      if (DONE !== 1'b1 || BUSY !== 1'b0) begin
         miss++; $display("FAIL zero_done: done=%b busy=%b, want 1 0", DONE, BUSY);
      end
      repeat (3) @(negedge CLK);
      vec++;
      if (wq_cyc.size() != 0 || wr_cnt !== '0) begin
         miss++; $display("FAIL zero_writes: seen=%0d wr_cnt=%0d, want 0 0", wq_cyc.size(), wr_cnt);
      end
      START = 1'b0;
      @(negedge CLK);

      NSAMP = 16'd50; START = 1'b1;
      repeat (6) @(negedge CLK);
      vec++;
      if (fifo_wr_en !== 1'b1 || BUSY !== 1'b1) begin
         miss++; $display("FAIL rst_precond: en=%b busy=%b, want 1 1", fifo_wr_en, BUSY);
      end
      #2 RST_N = 1'b0; START = 1'b0;
      #1;
      vec++;
      if ({fifo_wr_en, BUSY, DONE, OVF} !== 4'b0 || wr_cnt !== '0 || fifo_wr_data !== '0) begin
         miss++;
         $display("FAIL rst_async: en/busy/done/ovf=%b wr_cnt=%0d data=%h, want all 0",
                  {fifo_wr_en, BUSY, DONE, OVF}, wr_cnt, fifo_wr_data);
      end
      wq_dat.delete(); wq_cyc.delete();
      @(negedge CLK);
      #2 RST_N = 1'b1;
      repeat (10) @(negedge CLK);
      vec++;
      if (wq_cyc.size() != 0 || BUSY !== 1'b0) begin
         miss++; $display("FAIL rst_quiet: writes=%0d busy=%b, want 0 0", wq_cyc.size(), BUSY);
      end

      NSAMP = 16'd2; START = 1'b1; e0 = cyc + 1;
      repeat (4) @(negedge CLK);
      vec++;
      if (wq_cyc.size() != 2 || DONE !== 1'b1 || (wq_cyc.size() == 2 && wq_cyc[1] != e0 + 2)) begin
         miss++; $display("FAIL rst_restart: writes=%0d done=%b, want 2 1 (last at %0d)", wq_cyc.size(), DONE, e0 + 2);
      end
      START = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_decim();
      test_overflow();
      test_stop();
      test_zero_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
